// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS run controller: FSM states, end-of-run status codes
// and the default halt address.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_RUN        = 2'd1,
    ST_DONE       = 2'd2
  } run_state_e;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_HALT    = 2'b01;
  localparam logic [1:0] STAT_LOOP    = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_3ffc;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined MIPS core: core reset pulse, end-of-program detection
// (halt / self-loop / timeout) and run statistics. Optional stall counter: STALL_CNT_EN.
module cpu_run_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 10,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR,
  parameter int unsigned LOOP_LIMIT   = 8,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart_i,
  input  logic [31:0]      pc_i,
  input  logic             retire_i,
  input  logic             stall_i,
  output logic             core_reset_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int unsigned LOOP_W = $clog2(LOOP_LIMIT + 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       prev_pc_q, prev_pc_d;
  logic              prev_vld_q, prev_vld_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [1:0]        status_q, status_d;
  logic              restart_clr_c;
  logic              cnt_clr_c;
  logic              run_c;
  logic              pc_match_c;
  logic              halt_hit_c;
  logic              loop_hit_c;
  logic              tmo_hit_c;

  // End-of-program detectors, all evaluated on the current RUN-cycle inputs
  assign run_c      = (state_q == ST_RUN);
  assign pc_match_c = prev_vld_q && (pc_i == prev_pc_q);
  assign halt_hit_c = (pc_i == HALT_ADDR);
  assign loop_hit_c = !stall_i && pc_match_c && (loop_q == LOOP_W'(LOOP_LIMIT - 1));
  assign tmo_hit_c  = (64'(cycle_cnt_o) == 64'(MAX_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    prev_pc_d     = prev_pc_q;
    prev_vld_d    = prev_vld_q;
    loop_d        = loop_q;
    status_d      = status_q;
    restart_clr_c = 1'b0;
    unique case (state_q)
      ST_RESET_HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d    = ST_RUN;
          hold_d     = '0;
          prev_pc_d  = '0;
          prev_vld_d = 1'b0;
          loop_d     = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        prev_pc_d  = pc_i;
        prev_vld_d = 1'b1;
        // Stalled cycles neither advance nor break a self-loop run
        if (!stall_i) begin
          loop_d = pc_match_c ? (loop_q + LOOP_W'(1)) : '0;
        end
        if (halt_hit_c) begin
          state_d  = ST_DONE;
          status_d = STAT_HALT;
        end else if (loop_hit_c) begin
          state_d  = ST_DONE;
          status_d = STAT_LOOP;
        end else if (tmo_hit_c) begin
          state_d  = ST_DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      ST_DONE: begin
        if (restart_i) begin
          state_d       = ST_RESET_HOLD;
          hold_d        = '0;
          status_d      = STAT_NONE;
          restart_clr_c = 1'b1;
        end
      end
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET_HOLD;
      hold_q     <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      loop_q     <= '0;
      status_q   <= STAT_NONE;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      loop_q     <= loop_d;
      status_q   <= status_d;
    end
  end

  assign cnt_clr_c = reset || restart_clr_c;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .clr_i   (cnt_clr_c),
    .inc_i   (run_c),
    .count_o (cycle_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk     (clk),
    .clr_i   (cnt_clr_c),
    .inc_i   (run_c && retire_i),
    .count_o (retire_cnt_o)
  );

`ifdef STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clr_i   (cnt_clr_c),
    .inc_i   (run_c && stall_i),
    .count_o (stall_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
`endif

  assign core_reset_o = (state_q == ST_RESET_HOLD);
  assign running_o    = run_c;
  assign done_o       = (state_q == ST_DONE);
  assign status_o     = status_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances share stimulus (long budget, short
// timeout budget, 4-bit counters) so one sequence covers halt, loop, timeout and saturation.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic [31:0] pc;
  logic        retire;
  logic        stall;

  logic        a_crst, a_run, a_done;
  logic [1:0]  a_stat;
  logic [31:0] a_cyc, a_ret, a_stl;
  logic        b_crst, b_run, b_done;
  logic [1:0]  b_stat;
  logic [31:0] b_cyc, b_ret, b_stl;
  logic        c_crst, c_run, c_done;
  logic [1:0]  c_stat;
  logic [3:0]  c_cyc, c_ret, c_stl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RESET_CYCLES(4), .LOOP_LIMIT(8), .MAX_CYCLES(2000), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .restart_i(restart), .pc_i(pc), .retire_i(retire),
    .stall_i(stall), .core_reset_o(a_crst), .running_o(a_run), .done_o(a_done),
    .status_o(a_stat), .cycle_cnt_o(a_cyc), .retire_cnt_o(a_ret), .stall_cnt_o(a_stl));

  cpu_run_ctrl #(.RESET_CYCLES(4), .LOOP_LIMIT(8), .MAX_CYCLES(50), .CNT_W(32)) u_b (
    .clk(clk), .reset(reset), .restart_i(restart), .pc_i(pc), .retire_i(retire),
    .stall_i(stall), .core_reset_o(b_crst), .running_o(b_run), .done_o(b_done),
    .status_o(b_stat), .cycle_cnt_o(b_cyc), .retire_cnt_o(b_ret), .stall_cnt_o(b_stl));

  cpu_run_ctrl #(.RESET_CYCLES(4), .LOOP_LIMIT(8), .MAX_CYCLES(100000), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .restart_i(restart), .pc_i(pc), .retire_i(retire),
    .stall_i(stall), .core_reset_o(c_crst), .running_o(c_run), .done_o(c_done),
    .status_o(c_stat), .cycle_cnt_o(c_cyc), .retire_cnt_o(c_ret), .stall_cnt_o(c_stl));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset   = 1'b1;
    restart = 1'b0;
    pc      = 32'h0;
    retire  = 1'b0;
    stall   = 1'b0;

    // Reset state and RESET_HOLD length
    repeat (3) tick();
    chk("rst_core_reset", 64'(a_crst), 64'd1);
    chk("rst_running", 64'(a_run), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_status", 64'(a_stat), 64'd0);
    chk("rst_cycle", 64'(a_cyc), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("hold_edge3_core_reset", 64'(a_crst), 64'd1);
    chk("hold_edge3_running", 64'(a_run), 64'd0);
    tick();
    chk("hold_edge4_core_reset", 64'(a_crst), 64'd0);
    chk("hold_edge4_running", 64'(a_run), 64'd1);

    // Incrementing PC to HALT_ADDR; B times out, C saturates
    retire = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      tick();
      if (i == 1022) chk("halt_pre_done", 64'(a_done), 64'd0);
    end
    chk("halt_done", 64'(a_done), 64'd1);
    chk("halt_status", 64'(a_stat), 64'd1);
    chk("halt_cycle", 64'(a_cyc), 64'd1024);
    chk("halt_retire", 64'(a_ret), 64'd1024);
    chk("tmo_done", 64'(b_done), 64'd1);
    chk("tmo_status", 64'(b_stat), 64'd3);
    chk("tmo_cycle", 64'(b_cyc), 64'd50);
    chk("tmo_retire", 64'(b_ret), 64'd50);
    chk("sat_cycle", 64'(c_cyc), 64'd15);
    chk("sat_retire", 64'(c_ret), 64'd15);
    chk("sat_status", 64'(c_stat), 64'd1);

    // DONE freezes counters; late retires ignored
    pc = 32'h0000_0100;
    repeat (3) tick();
    chk("done_freeze_retire", 64'(a_ret), 64'd1024);
    chk("done_freeze_cycle", 64'(a_cyc), 64'd1024);
    chk("done_core_reset", 64'(a_crst), 64'd0);

    // restart in DONE
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_core_reset", 64'(a_crst), 64'd1);
    chk("restart_cycle", 64'(a_cyc), 64'd0);
    chk("restart_retire", 64'(a_ret), 64'd0);
    chk("restart_status", 64'(a_stat), 64'd0);
    chk("restart_done", 64'(a_done), 64'd0);
    repeat (4) tick();
    chk("restart_running", 64'(a_run), 64'd1);

    // Self-loop without stalls: 1 first cycle + 8 equal-PC cycles
    retire = 1'b0;
    pc     = 32'h3010;
    repeat (8) tick();
    chk("loop_pre_done", 64'(a_done), 64'd0);
    tick();
    chk("loop_done", 64'(a_done), 64'd1);
    chk("loop_status", 64'(a_stat), 64'd2);
    chk("loop_cycle", 64'(a_cyc), 64'd9);

    // Self-loop with stalls every other cycle; restart in RUN ignored
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      restart = (k == 1);
      stall   = (k % 2 == 0);
      pc      = 32'h3010;
      tick();
      if (k == 1) chk("run_restart_ignored", 64'(a_run), 64'd1);
      if (k == 16) chk("stall_loop_pre_done", 64'(a_done), 64'd0);
    end
    restart = 1'b0;
    stall   = 1'b0;
    chk("stall_loop_done", 64'(a_done), 64'd1);
    chk("stall_loop_status", 64'(a_stat), 64'd2);
    chk("stall_loop_cycle", 64'(a_cyc), 64'd17);
`ifdef STALL_CNT_EN
    chk("stall_cnt", 64'(a_stl), 64'd8);
`else
    chk("stall_cnt", 64'(a_stl), 64'd0);
`endif

    // Halt coinciding with timeout on B: halt wins
    do_reset();
    for (int i = 0; i < 50; i++) begin
      pc = 32'h3f38 + 32'(4 * i);
      tick();
    end
    chk("coincide_status", 64'(b_stat), 64'd1);
    chk("coincide_cycle", 64'(b_cyc), 64'd50);
    chk("coincide_a_status", 64'(a_stat), 64'd1);

    // reset in the middle of RUN
    do_reset();
    retire = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      tick();
    end
    chk("midrun_cycle", 64'(a_cyc), 64'd30);
    chk("midrun_retire", 64'(a_ret), 64'd30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_cycle", 64'(a_cyc), 64'd0);
    chk("midrst_retire", 64'(a_ret), 64'd0);
    chk("midrst_core_reset", 64'(a_crst), 64'd1);
    chk("midrst_running", 64'(a_run), 64'd0);
    chk("midrst_status", 64'(a_stat), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
